// File: rtl/inertial_interface.sv
// Inertial front end: powers up and configures the IMU over the SPI engine, then on each
// data-ready interrupt reads pitch rate and Z acceleration and presents them as one sample.
module inertial_interface #(
  parameter int TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] inert_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  // Handshake: wrt is a one-cycle request carrying cmd; the FSM then waits in the
  // command state for the engine's one-cycle done before issuing anything else.
  typedef enum logic [3:0] {
    INIT_WAIT, CFG1, CFG2, CFG3, CFG4, IDLE, RD_PL, RD_PH, RD_AL, RD_AH
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               int_meta_q, int_meta_d;
  logic               int_s_q, int_s_d;
  logic [7:0]         pitch_l_q, pitch_l_d;
  logic [7:0]         pitch_h_q, pitch_h_d;
  logic [7:0]         az_l_q, az_l_d;
  logic [7:0]         az_h_q, az_h_d;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               vld_q, vld_d;
  logic [15:0]        ptch_q, ptch_d;
  logic [15:0]        az_q, az_d;

  // Only the low byte of each SPI word carries register data.
  logic unused_hi;
  assign unused_hi = ^inert_data[15:8];

  function automatic logic [15:0] cmd_for(input state_t s);
    logic [15:0] c;
    case (s)
      CFG1:    c = 16'h0D02;
      CFG2:    c = 16'h1053;
      CFG3:    c = 16'h1150;
      CFG4:    c = 16'h1460;
      RD_PL:   c = 16'hA400;
      RD_PH:   c = 16'hA500;
      RD_AL:   c = 16'hAC00;
      RD_AH:   c = 16'hAD00;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    int_meta_d = INT;
    int_s_d    = int_meta_q;
    pitch_l_d  = pitch_l_q;
    pitch_h_d  = pitch_h_q;
    az_l_d     = az_l_q;
    az_h_d     = az_h_q;
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    vld_d      = 1'b0;
    ptch_d     = ptch_q;
    az_d       = az_q;

    case (state_q)
      INIT_WAIT: begin
        if (&timer_q) state_d = CFG1;
        else          timer_d = timer_q + 1'b1;
      end
      CFG1: if (done) state_d = CFG2;
      CFG2: if (done) state_d = CFG3;
      CFG3: if (done) state_d = CFG4;
      CFG4: if (done) state_d = IDLE;
      IDLE: if (int_s_q) state_d = RD_PL;
      RD_PL: if (done) begin
        pitch_l_d = inert_data[7:0];
        state_d   = RD_PH;
      end
      RD_PH: if (done) begin
        pitch_h_d = inert_data[7:0];
        state_d   = RD_AL;
      end
      RD_AL: if (done) begin
        az_l_d  = inert_data[7:0];
        state_d = RD_AH;
      end
      RD_AH: if (done) begin
        // Both words load in the same edge so a partial sample is never visible.
        az_h_d  = inert_data[7:0];
        ptch_d  = {pitch_h_q, pitch_l_q};
        az_d    = {az_h_d, az_l_q};
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT_WAIT;
    endcase

    if ((state_d != state_q) && (state_d != IDLE) && (state_d != INIT_WAIT)) begin
      wrt_d = 1'b1;
      cmd_d = cmd_for(state_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_WAIT;
      timer_q    <= '0;
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
      pitch_l_q  <= 8'h00;
      pitch_h_q  <= 8'h00;
      az_l_q     <= 8'h00;
      az_h_q     <= 8'h00;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      vld_q      <= 1'b0;
      ptch_q     <= 16'h0000;
      az_q       <= 16'h0000;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      int_meta_q <= int_meta_d;
      int_s_q    <= int_s_d;
      pitch_l_q  <= pitch_l_d;
      pitch_h_q  <= pitch_h_d;
      az_l_q     <= az_l_d;
      az_h_q     <= az_h_d;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      vld_q      <= vld_d;
      ptch_q     <= ptch_d;
      az_q       <= az_d;
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptch_q;
  assign AZ      = az_q;

endmodule

// File: tb/tb_inertial_interface.sv
// Bench for inertial_interface: an SPI responder backed by an IMU register-file model
// supplies read data; every delivered sample is compared with the model's registers.
module tb_inertial_interface;
  localparam int TMR_W = 4;

  logic        clk = 1'b0;
  logic        rst_n, INT, done, wrt, vld;
  logic [15:0] inert_data, cmd, ptch_rt, AZ;

  always #5 clk = ~clk;

  inertial_interface #(.TMR_W(TMR_W)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .inert_data(inert_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ)
  );

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, vld_cnt = 0, rd_wrt_cnt = 0, rel_cyc = 0, first_wrt_cyc = 0;
  int cnt_left = 0;
  bit await_first = 0, rand_delay = 0, pending = 0, busy = 0, pend_read = 0;
  logic [7:0]  pend_byte = 8'h00;
  logic [6:0]  pend_addr = 7'h00;
  logic [15:0] act_q[$];
  logic [7:0]  dir_q[$];
  int          delay_q[$];
  bit   [7:0]  reg_val [128];
  logic [15:0] last_p = 16'h0000, last_a = 16'h0000;
  logic [15:0] cfg_cmds[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_cmds[4]  = '{16'hA400, 16'hA500, 16'hAC00, 16'hAD00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // SPI responder + output monitor, sampled 1 time unit after each rising edge.
  initial begin
    done = 1'b0;
    inert_data = 16'h0000;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      done = 1'b0;
      busy = pending;
      if (!rst_n) begin
        pending = 0;
        last_p = 16'h0000;
        last_a = 16'h0000;
      end else begin
        if (pending) begin
          cnt_left--;
          if (cnt_left <= 0) begin
            done = 1'b1;
            inert_data = {8'($urandom), pend_byte};
            if (pend_read) reg_val[pend_addr] = pend_byte;
            pending = 0;
          end
        end
        if (wrt) begin
          check("wrt_overlap", {31'd0, busy}, 32'd0);
          act_q.push_back(cmd);
          if (cmd[15]) rd_wrt_cnt++;
          if (await_first) begin
            first_wrt_cyc = cyc;
            await_first = 0;
          end
          pending   = 1;
          cnt_left  = (delay_q.size() > 0) ? delay_q.pop_front()
                    : (rand_delay ? int'($urandom_range(1, 12)) : 10);
          pend_read = cmd[15];
          pend_addr = cmd[14:8];
          pend_byte = cmd[15] ? ((dir_q.size() > 0) ? dir_q.pop_front() : 8'($urandom)) : 8'h00;
        end
        if (vld) begin
          vld_cnt++;
          check("vld_ptch_rt", {16'h0, ptch_rt}, {16'h0, reg_val[7'h25], reg_val[7'h24]});
          check("vld_az", {16'h0, AZ}, {16'h0, reg_val[7'h2D], reg_val[7'h2C]});
          last_p = ptch_rt;
          last_a = AZ;
        end else begin
          check("sample_hold", {ptch_rt, AZ}, {last_p, last_a});
        end
      end
    end
  end

  // sel: 0 = vld count, 1 = read-wrt count, 2 = total wrt count.
  task automatic wait_for(input int sel, input int target, input int budget, input string tag);
    int n = 0;
    int cur;
    cur = (sel == 0) ? vld_cnt : (sel == 1) ? rd_wrt_cnt : act_q.size();
    while (n < budget && cur < target) begin
      @(posedge clk);
      #2;
      n++;
      cur = (sel == 0) ? vld_cnt : (sel == 1) ? rd_wrt_cnt : act_q.size();
    end
    check(tag, {31'd0, cur >= target}, 32'd1);
  endtask

  task automatic pulse_int();
    @(negedge clk) INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int base, input bit rd);
    for (int i = 0; i < 4; i++)
      check(tag, {16'h0, act_q[base + i]}, {16'h0, rd ? rd_cmds[i] : cfg_cmds[i]});
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, {wrt, vld, 14'd0, cmd}, 32'd0);
    check(tag, {ptch_rt, AZ}, 32'd0);
  endtask

  initial begin
    int v0, r0, q0;
    rst_n = 1'b0;
    INT   = 1'b0;

    // Power-up and configuration
    repeat (3) @(posedge clk);
    #1 check_outs_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;
    rel_cyc = cyc;
    await_first = 1;
    wait_for(2, 4, 400, "cfg_wrts_timeout");
    repeat (20) @(posedge clk);
    #2;
    check_seq("cfg_cmd", 0, 0);
    check("cfg_first_wrt_delay", {31'd0, (first_wrt_cyc - rel_cyc) >= 15}, 32'd1);
    check("cfg_no_vld", vld_cnt, 0);

    // Directed read
    q0 = act_q.size();
    v0 = vld_cnt;
    dir_q = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    pulse_int();
    wait_for(0, v0 + 1, 300, "rd1_vld_timeout");
    repeat (5) @(posedge clk);
    #2;
    check("rd1_ptch_rt", {16'h0, last_p}, 32'h0000_1234);
    check("rd1_az", {16'h0, last_a}, 32'h0000_ABCD);
    check("rd1_vld_count", vld_cnt - v0, 1);
    check_seq("rd1_cmd", q0, 1);

    // Sign extremes, then stability
    v0 = vld_cnt;
    rand_delay = 1;
    dir_q = '{8'h00, 8'h80, 8'hFF, 8'hFF};
    pulse_int();
    wait_for(0, v0 + 1, 300, "rd2_vld_timeout");
    repeat (20) @(posedge clk);
    #2;
    check("rd2_ptch_rt", {16'h0, ptch_rt}, 32'h0000_8000);
    check("rd2_az", {16'h0, AZ}, 32'h0000_FFFF);

    // INT held high: back-to-back sequences with random data and delays
    v0 = vld_cnt;
    r0 = rd_wrt_cnt;
    @(negedge clk) INT = 1'b1;
    wait_for(0, v0 + 2, 400, "held_vld2_timeout");
    repeat (3) @(posedge clk);
    @(negedge clk) INT = 1'b0;
    wait_for(0, v0 + 3, 300, "held_vld3_timeout");
    repeat (60) @(posedge clk);
    #2;
    check("held_vld_count", vld_cnt - v0, 3);
    check("held_rd_wrts", rd_wrt_cnt - r0, 12);

    // INT toggled while RD_PH waits 50 clk for done
    v0 = vld_cnt;
    r0 = rd_wrt_cnt;
    q0 = act_q.size();
    rand_delay = 0;
    delay_q = '{10, 50, 10, 10};
    pulse_int();
    wait_for(1, r0 + 2, 200, "stall_rdph_timeout");
    repeat (5) @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    repeat (3) @(negedge clk);
    INT = 1'b1;
    @(negedge clk) INT = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("stall_no_extra_wrt", rd_wrt_cnt - r0, 2);
    wait_for(0, v0 + 1, 300, "stall_vld_timeout");
    repeat (80) @(posedge clk);
    #2;
    check("stall_vld_count", vld_cnt - v0, 1);
    check("stall_rd_wrts", rd_wrt_cnt - r0, 4);
    check_seq("stall_cmd", q0, 1);

    // Reset in RD_AL
    v0 = vld_cnt;
    r0 = rd_wrt_cnt;
    rand_delay = 1;
    pulse_int();
    wait_for(1, r0 + 3, 200, "rst_rdal_timeout");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("midrst_outputs");
    repeat (3) @(negedge clk);
    q0 = act_q.size();
    rst_n = 1'b1;
    rel_cyc = cyc;
    await_first = 1;
    wait_for(2, q0 + 4, 400, "recfg_wrts_timeout");
    repeat (20) @(posedge clk);
    #2;
    check_seq("recfg_cmd", q0, 0);
    check("recfg_first_wrt_delay", {31'd0, (first_wrt_cyc - rel_cyc) >= 15}, 32'd1);
    check("recfg_no_vld", vld_cnt - v0, 0);
    check("recfg_rd_wrts", rd_wrt_cnt - r0, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inertial_interface.md
Name: inertial_interface

Overview:
- SPI-side front end of the inertial path: brings the 6-axis IMU out of power-up, configures it, then services each data-ready interrupt.
- Each service reads pitch rate and Z-acceleration, and delivers ptch_rt, AZ and a one-cycle vld strobe to the pitch integrator.
- Drives an existing 16-bit SPI transaction engine through a wrt/done handshake; never touches SCLK/MOSI/MISO/SS_n directly.

Parameters:
- TMR_W, 16, width of the power-up delay counter; init starts when the counter is all-ones (2^TMR_W−1 cycles). Benches use a small value, e.g. 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- INT  in  1  IMU data-ready interrupt; asynchronous to clk
- done  in  1  SPI engine: transaction complete, one-cycle pulse; inert_data valid in that cycle
- inert_data  in  16  SPI engine: received word; only bits [7:0] are used
- wrt  out  1  one-cycle request to the SPI engine to start a transaction with cmd
- cmd  out  16  SPI command word: {R/W̄ + address, data}
- vld  out  1  one-cycle strobe: ptch_rt and AZ hold a new coherent sample
- ptch_rt  out  16  signed gyro pitch rate {pitchH, pitchL}
- AZ  out  16  signed Z acceleration {AZH, AZL}

Behaviour:
- Reset: clk is clk; rst_n is asynchronous, active-low. All flops clear asynchronously: state=INIT_WAIT, timer=0, INT synchronizer=0, byte holds=0, wrt=0, cmd=0, vld=0, ptch_rt=0, AZ=0.
- INT synchronizer: two flops. INT_s is the second stage. INT is used only through INT_s.
- Timer: TMR_W-bit up-counter; runs only in INT_WAIT. It does not wrap: it saturates at all-ones.
- States and commands, in order:
  - INIT_WAIT: leave when timer is all-ones.
  - CFG1, cmd 16'h0D02: INT1 on data-ready.
  - CFG2, cmd 16'h1053: accel 208 Hz, ±2 g.
  - CFG3, cmd 16'h1150: gyro 208 Hz, 250 dps.
  - CFG4, cmd 16'h1460: rounding on.
  - IDLE.
  - RD_PL, cmd 16'hA400.
  - RD_PH, cmd 16'hA500.
  - RD_AL, cmd 16'hAC00.
  - RD_AH, cmd 16'hAD00.
  - back to IDLE.
- Handshake:
  - On entry to each command state, wrt=1 for exactly one cycle. cmd is registered and presented in that same cycle.
  - cmd holds its value until the next wrt.
  - The FSM stays in the state until done=1, then advances on the next edge.
  - At most one wrt is outstanding at a time.
  - done is ignored in INIT_WAIT and IDLE.
- Read capture: in RD_PL/RD_PH/RD_AL/RD_AH, on done, inert_data[7:0] is latched into pitchL/pitchH/AZL/AZH respectively.
- Output update:
  - ptch_rt and AZ update together on the edge after RD_AH's done. vld=1 in that same cycle only.
  - Between updates, ptch_rt and AZ are stable. No partial sample is ever visible.
- Service trigger:
  - IDLE→RD_PL when INT_s=1. The first wrt follows on the next cycle.
  - INT_s is sampled only in IDLE; INT edges during a read sequence are not queued.
  - If INT stays high, a new read sequence starts immediately on return to IDLE.
- Latency: INT rising to first wrt is 3–4 clk. RD_AH done to vld is 1 clk.
- Reset mid-operation: all state is lost and the power-up delay and configuration fully restart. No stale vld is produced.

Test Plan:
- Reset, TMR_W=4, done returned 10 clk after each wrt, INT=0 → wrt pulses with cmd 0D02, 1053, 1150, 1460 in order. First wrt occurs no earlier than 15 clk after reset release. vld never asserts.
- After init, INT pulse; responder returns 8'h34, 8'h12, 8'hCD, 8'hAB → exactly one vld, with ptch_rt=16'h1234 and AZ=16'hABCD in that cycle. Read cmds are A400, A500, AC00, AD00.
- Sign check: bytes 8'h00, 8'h80, 8'hFF, 8'hFF → ptch_rt=−32768, AZ=−1. Values stay stable until the next vld.
- INT held high for 3 full sequences → 3 vld pulses, 12 read wrts, no overlapping wrt before done.
- INT toggled during RD_PH, done withheld 50 clk → FSM holds in RD_PH with no extra wrt and no sequence restart. Exactly one vld follows.
- rst_n asserted in RD_AL → all outputs 0 immediately. After release, the full delay and the four config writes repeat with no vld.
